// File: rtl/bus_mux_arb.sv
// Handshaked N-to-1 bus multiplexer with a one-word registered output stage.
// The default build selects the channel given by S; define BUS_MUX_RR_EN to select by round-robin arbitration over in_valid.
module bus_mux_arb #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [SELW-1:0]       S,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      Q,
  output logic                  Q_valid,
  input  logic                  Q_ready,
  output logic [SELW-1:0]       Q_ch
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;

  logic [WIDTH-1:0]  chan [NCH];
  logic [SELW-1:0]   grant;
  logic              grant_vld;
  logic              can_accept;
  logic              xfer;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi]     = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = grant_vld && can_accept && (grant == SELW'(gi));
    end
  endgenerate

`ifdef BUS_MUX_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW:0]   idx;

  // First valid channel at or above the pointer, wrapping at NCH.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr_q} + (SELW+1)'(i);
      if (idx >= (SELW+1)'(NCH)) idx = idx - (SELW+1)'(NCH);
      if (!grant_vld && in_valid[idx[SELW-1:0]]) begin
        grant     = idx[SELW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant == SELW'(NCH-1)) ? '0 : grant + SELW'(1);
  end
`else
  assign grant     = S;
  assign grant_vld = ({1'b0, S} < (SELW+1)'(NCH));
`endif

  assign can_accept = (state_q == EMPTY) || Q_ready;
  assign xfer       = grant_vld && can_accept && in_valid[grant];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = chan[grant];
      ch_d    = grant;
    end else if (state_q == FULL && Q_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
`ifdef BUS_MUX_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
`ifdef BUS_MUX_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign Q       = data_q;
  assign Q_ch    = ch_q;
  assign Q_valid = (state_q == FULL);

endmodule

// File: tb/tb_bus_mux_arb.sv
// Self-checking bench for bus_mux_arb: vector table plus scoreboard of expected output words.
module tb_bus_mux_arb;

  typedef struct {
    logic [1:0]  s;
    logic [3:0]  iv;
    logic [63:0] data;
    logic        qr;
    logic [3:0]  exp_ir;
    logic        exp_qv;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ch;
  } word_t;

  localparam logic [63:0] JUNK = 64'h0D0D_0C0C_0B0B_0A0A;
`ifdef BUS_MUX_RR_EN
  localparam logic [3:0] IDLE_IR = 4'b0000;
`else
  localparam logic [3:0] IDLE_IR = 4'b1000;
`endif

  logic        clk = 1'b0;
  logic        Resetn;
  logic [1:0]  S;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] Q;
  logic        Q_valid;
  logic        Q_ready;
  logic [1:0]  Q_ch;

  logic [1:0]  s3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [15:0] q3;
  logic        q_valid3;
  logic        q_ready3;
  logic [1:0]  q_ch3;

  int errors = 0;
  int checks = 0;
  vec_t  tbl[$];
  word_t sb[$];

  always #5 clk = ~clk;

  bus_mux_arb #(.WIDTH(16), .NCH(4), .SELW(2)) dut (
    .Clock(clk), .Resetn(Resetn), .S(S), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .Q(Q), .Q_valid(Q_valid), .Q_ready(Q_ready), .Q_ch(Q_ch)
  );

  bus_mux_arb #(.WIDTH(16), .NCH(3), .SELW(2)) dut3 (
    .Clock(clk), .Resetn(Resetn), .S(s3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .Q(q3), .Q_valid(q_valid3), .Q_ready(q_ready3), .Q_ch(q_ch3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] put(input int ch, input logic [15:0] v);
    logic [63:0] d;
    d = JUNK;
    d[ch*16 +: 16] = v;
    return d;
  endfunction

  function automatic void add(input logic [1:0] s, input logic [3:0] iv, input logic [63:0] d,
                              input logic qr, input logic [3:0] ir, input logic qv);
    vec_t v;
    v.s = s; v.iv = iv; v.data = d; v.qr = qr; v.exp_ir = ir; v.exp_qv = qv;
    tbl.push_back(v);
  endfunction

  // Drive one cycle, check at the falling edge, update the scoreboard for the coming edge.
  task automatic step(input vec_t v, input int n);
    word_t w;
    S = v.s; in_valid = v.iv; in_data = v.data; Q_ready = v.qr;
    @(negedge clk);
    chk($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(v.exp_ir));
    chk($sformatf("Q_valid[%0d]", n), 32'(Q_valid), 32'(v.exp_qv));
    if (v.exp_qv) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard[%0d]: got Q=%h with no expected word", n, Q);
      end else begin
        chk($sformatf("Q[%0d]", n), 32'(Q), 32'(sb[0].data));
        chk($sformatf("Q_ch[%0d]", n), 32'(Q_ch), 32'(sb[0].ch));
        if (v.qr) void'(sb.pop_front());
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (v.iv[k] && v.exp_ir[k]) begin
        w.data = v.data[k*16 +: 16];
        w.ch   = 2'(k);
        sb.push_back(w);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn = 1'b0; S = '0; in_valid = '0; in_data = '0; Q_ready = 1'b0;
    s3 = 2'd3; in_valid3 = 3'b111; in_data3 = 48'h3333_2222_1111; q_ready3 = 1'b1;
    #23;
    chk("reset Q", 32'(Q), 32'h0);
    chk("reset Q_valid", 32'(Q_valid), 32'h0);
    chk("reset Q_ch", 32'(Q_ch), 32'h0);
    @(negedge clk); Resetn = 1'b1;
    @(posedge clk); #1;

`ifndef BUS_MUX_RR_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("nch3 in_ready[%0d]", c), 32'(in_ready3), 32'h0);
      chk($sformatf("nch3 Q_valid[%0d]", c), 32'(q_valid3), 32'h0);
      @(posedge clk); #1;
    end
    add(2'd2, 4'b0100, put(2, 16'hA5A5), 1'b1, 4'b0100, 1'b0);
    add(2'd2, 4'b0000, put(2, 16'h0000), 1'b1, 4'b0100, 1'b1);
    add(2'd1, 4'b0010, put(1, 16'h1111), 1'b0, 4'b0010, 1'b0);
    for (int c = 0; c < 3; c++) add(2'd1, 4'b0010, put(1, 16'h2222), 1'b0, 4'b0000, 1'b1);
    add(2'd1, 4'b0010, put(1, 16'h2222), 1'b1, 4'b0010, 1'b1);
    add(2'd1, 4'b0000, put(1, 16'h0000), 1'b1, 4'b0010, 1'b1);
    for (int c = 1; c <= 4; c++) add(2'd1, 4'b0010, put(1, 16'(c)), 1'b1, 4'b0010, c != 1);
    add(2'd1, 4'b0000, put(1, 16'h0000), 1'b1, 4'b0010, 1'b1);
    add(2'd3, 4'b1111, put(3, 16'hDEAD), 1'b1, 4'b1000, 1'b0);
    add(2'd0, 4'b1110, put(0, 16'h0777), 1'b1, 4'b0001, 1'b1);
    add(2'd0, 4'b1110, put(0, 16'h0777), 1'b1, 4'b0001, 1'b0);
`else
    for (int c = 0; c < 5; c++)
      add(2'd2, 4'b1111, 64'h0D03_0C02_0B01_0A00, 1'b1, 4'(1 << (c % 4)), c != 0);
    add(2'd0, 4'b1000, 64'h0D03_0C02_0B01_0A00, 1'b1, 4'b1000, 1'b1);
    add(2'd3, 4'b1001, 64'h0D13_0C12_0B11_0A10, 1'b1, 4'b0001, 1'b1);
    add(2'd0, 4'b0000, JUNK, 1'b1, 4'b0000, 1'b1);
    add(2'd0, 4'b0000, JUNK, 1'b1, 4'b0000, 1'b0);
    add(2'd0, 4'b0100, put(2, 16'h1111), 1'b0, 4'b0100, 1'b0);
    add(2'd0, 4'b0100, put(2, 16'h2222), 1'b0, 4'b0000, 1'b1);
    add(2'd0, 4'b0000, JUNK, 1'b1, 4'b0000, 1'b1);
    add(2'd0, 4'b0000, JUNK, 1'b1, 4'b0000, 1'b0);
`endif
    foreach (tbl[i]) step(tbl[i], i);

    // Asynchronous reset while holding a word: it must vanish and never reappear.
    begin
      vec_t v;
      v.s = 2'd3; v.iv = 4'b1000; v.data = put(3, 16'hBEEF); v.qr = 1'b0; v.exp_ir = 4'b1000; v.exp_qv = 1'b0;
      step(v, 100);
      v.iv = 4'b0000; v.exp_ir = 4'b0000; v.exp_qv = 1'b1;
      step(v, 101);
      #3 Resetn = 1'b0;
      #1;
      chk("async reset Q", 32'(Q), 32'h0);
      chk("async reset Q_valid", 32'(Q_valid), 32'h0);
      chk("async reset Q_ch", 32'(Q_ch), 32'h0);
      sb.delete();
      Q_ready = 1'b1;
      #2 Resetn = 1'b1;
      @(posedge clk); #1;
      v.qr = 1'b1; v.exp_ir = IDLE_IR; v.exp_qv = 1'b0;
      for (int c = 0; c < 3; c++) step(v, 102 + c);
    end

    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
